// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit controller.
// The optional parity stage is selected at build time with UART_TX_PARITY_EN.
package uart_pkg;

  localparam int DVSR_W = 11;
  localparam int DBIT_DEFAULT = 8;
  localparam int OVS_DEFAULT = 16;
  localparam int SB_TICK_DEFAULT = 16;
  localparam logic [DVSR_W-1:0] DVSR_RST_DEFAULT = 11'd53;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Even parity over the data bits; callers zero-extend narrower words.
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Requester handshake and divisor-write bundle between the bus-side UART
// registers (master) and the transmit controller (slave).
interface uart_tx_ctrl_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DBIT    = DBIT_DEFAULT
);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*DBIT-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic [DVSR_W-1:0]       dvsr_wdata;
  logic                    dvsr_we;

  modport master (
    output req_valid, req_data, dvsr_wdata, dvsr_we,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_data, dvsr_wdata, dvsr_we,
    output req_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index at or after the
// rotating pointer; the pointer moves past the winner only when enabled.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx,
  output logic               any
);

  logic [IW-1:0] ptr_r;
  logic [IW-1:0] idx_s;
  logic          found_s;

  // Search requests starting from the pointer, wrapping once around.
  always_comb begin
    int j;
    idx_s   = '0;
    found_s = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_r) + k;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end else begin
        j = j;
      end
      if (!found_s && req[j]) begin
        found_s = 1'b1;
        idx_s   = IW'(j);
      end else begin
        found_s = found_s;
      end
    end
  end

  // One-hot grant, only while the owner allows arbitration.
  always_comb begin
    if (en && found_s) begin
      gnt = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx_s;
    end else begin
      gnt = '0;
    end
    gnt_idx = idx_s;
    any     = found_s;
  end

  // Rotating pointer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r <= '0;
    end else if (en && found_s) begin
      ptr_r <= (idx_s == IW'(NUM_REQ - 1)) ? '0 : idx_s + IW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: arbitrates requesters, serialises 8N1 frames off
// the oversampling tick and owns the baud divisor. Parity via UART_TX_PARITY_EN.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter  int                NUM_REQ  = 2,
  parameter  int                DBIT     = DBIT_DEFAULT,
  parameter  int                OVS      = OVS_DEFAULT,
  parameter  int                SB_TICK  = SB_TICK_DEFAULT,
  parameter  logic [DVSR_W-1:0] DVSR_RST = DVSR_RST_DEFAULT,
  localparam int                IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_tx_ctrl_if.slave     bus,
  output logic [DVSR_W-1:0] dvsr,
  input  logic              tick,
  output logic              tx,
  output logic              busy,
  output logic [IW-1:0]     grant_id
);

  localparam int         NW        = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [3:0] S_LAST    = 4'(OVS - 1);
  localparam logic [3:0] STOP_LAST = 4'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
`ifdef UART_TX_PARITY_EN
  localparam tx_state_t AFTER_DATA = PARITY;
`else
  localparam tx_state_t AFTER_DATA = STOP;
`endif

  tx_state_t          state_r, state_s;
  logic [3:0]         s_r, s_s;
  logic [NW-1:0]      n_r, n_s;
  logic [DBIT-1:0]    shift_r, shift_s;
  logic [DBIT-1:0]    sel_data_s;
  logic               tx_r, tx_s;
  logic               busy_r;
  logic [IW-1:0]      grant_id_r;
  logic [DVSR_W-1:0]  dvsr_r, pend_r;
  logic               pend_v_r;
  logic [NUM_REQ-1:0] gnt_s;
  logic [IW-1:0]      idx_s;
  logic               any_s;
  logic               arb_en_s;
  logic               grant_s;
  logic               entering_idle_s;
`ifdef UART_TX_PARITY_EN
  logic               par_r;
`endif

  assign arb_en_s        = (state_r == IDLE);
  assign grant_s         = arb_en_s && any_s;
  assign entering_idle_s = (state_r != IDLE) && (state_s == IDLE);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (bus.req_valid),
    .en      (arb_en_s),
    .gnt     (gnt_s),
    .gnt_idx (idx_s),
    .any     (any_s)
  );

  // Accept pulse is combinational so the winner sees it in the granting cycle.
  always_comb begin
    if (reset_n) begin
      bus.req_ready = gnt_s;
    end else begin
      bus.req_ready = '0;
    end
  end

  // Byte of the current winner.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_s[i]) begin
        sel_data_s = bus.req_data[i*DBIT +: DBIT];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Frame sequencer: next state, tick counter, bit counter and shifter.
  always_comb begin
    state_s = state_r;
    s_s     = s_r;
    n_s     = n_r;
    shift_s = shift_r;
    case (state_r)
      IDLE: begin
        s_s = 4'd0;
        if (grant_s) begin
          state_s = START;
          n_s     = '0;
          shift_s = sel_data_s;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (tick) begin
          if (s_r == S_LAST) begin
            s_s     = 4'd0;
            n_s     = '0;
            state_s = DATA;
          end else begin
            s_s = s_r + 4'd1;
          end
        end else begin
          s_s = s_r;
        end
      end
      DATA: begin
        if (tick) begin
          if (s_r == S_LAST) begin
            s_s     = 4'd0;
            shift_s = {1'b0, shift_r[DBIT-1:1]};
            if (n_r == N_LAST) begin
              state_s = AFTER_DATA;
            end else begin
              n_s = n_r + NW'(1);
            end
          end else begin
            s_s = s_r + 4'd1;
          end
        end else begin
          s_s = s_r;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s_r == S_LAST) begin
            s_s     = 4'd0;
            state_s = STOP;
          end else begin
            s_s = s_r + 4'd1;
          end
        end else begin
          s_s = s_r;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s_r == STOP_LAST) begin
            s_s     = 4'd0;
            state_s = IDLE;
          end else begin
            s_s = s_r + 4'd1;
          end
        end else begin
          s_s = s_r;
        end
      end
      default: begin
        state_s = IDLE;
        s_s     = 4'd0;
      end
    endcase
  end

  // Line level for the upcoming cycle, registered so tx is glitch-free.
  always_comb begin
    case (state_s)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_s = par_r;
`endif
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
  end

  // Sequencer and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      s_r        <= 4'd0;
      n_r        <= '0;
      shift_r    <= '0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      grant_id_r <= '0;
    end else begin
      state_r    <= state_s;
      s_r        <= s_s;
      n_r        <= n_s;
      shift_r    <= shift_s;
      tx_r       <= tx_s;
      busy_r     <= (state_s != IDLE);
      grant_id_r <= grant_s ? idx_s : grant_id_r;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is fixed at accept time, before the shifter consumes the byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_r <= 1'b0;
    end else if (grant_s) begin
      par_r <= even_parity(32'(sel_data_s));
    end else begin
      par_r <= par_r;
    end
  end
`endif

  // Divisor: writes during a frame (or its granting cycle) wait for IDLE entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dvsr_r   <= DVSR_RST;
      pend_r   <= '0;
      pend_v_r <= 1'b0;
    end else if (entering_idle_s) begin
      if (bus.dvsr_we) begin
        dvsr_r <= bus.dvsr_wdata;
      end else if (pend_v_r) begin
        dvsr_r <= pend_r;
      end else begin
        dvsr_r <= dvsr_r;
      end
      pend_v_r <= 1'b0;
    end else if (bus.dvsr_we) begin
      if (arb_en_s && !grant_s) begin
        dvsr_r <= bus.dvsr_wdata;
      end else begin
        pend_r   <= bus.dvsr_wdata;
        pend_v_r <= 1'b1;
      end
    end else begin
      dvsr_r <= dvsr_r;
    end
  end

  assign dvsr     = dvsr_r;
  assign tx       = tx_r;
  assign busy     = busy_r;
  assign grant_id = grant_id_r;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: frame-level reference model checked
// every cycle, plus directed literal checks and a randomized soak.
module tb_uart_tx_ctrl;
  import uart_pkg::*;

  localparam int NR = 2;
  localparam int DB = 8;
  localparam int OV = 16;
  localparam int SB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = OV * (1 + DB) + OV + SB;
`else
  localparam int FRAME = OV * (1 + DB) + SB;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick = 1'b0;
  logic [10:0] dvsr;
  logic        tx;
  logic        busy;
  logic [0:0]  grant_id;

  uart_tx_ctrl_if #(.NUM_REQ(NR), .DBIT(DB)) bus ();

  uart_tx_ctrl #(
    .NUM_REQ(NR), .DBIT(DB), .OVS(OV), .SB_TICK(SB), .DVSR_RST(11'd53)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .dvsr(dvsr),
    .tick(tick), .tx(tx), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b1;

  // Reference model: frame position counted in ticks, not in FSM states.
  bit          m_active = 1'b0;
  int          m_ticks = 0;
  logic [7:0]  m_data = 8'h00;
  int          m_ptr = 0;
  int          m_gid = 0;
  logic [10:0] m_dvsr = 11'd53;
  logic [10:0] m_pend = 11'd0;
  bit          m_pend_v = 1'b0;
  logic [1:0]  m_gnt = 2'b00;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [1:0] v, input int p);
    for (int k = 0; k < NR; k++) begin
      int j;
      j = (p + k) % NR;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic exp_tx();
    int t;
    if (!m_active) return 1'b1;
    t = m_ticks;
    if (t < OV) return 1'b0;
    if (t < OV * (1 + DB)) return m_data[(t - OV) / OV];
`ifdef UART_TX_PARITY_EN
    if (t < OV * (2 + DB)) return ^m_data;
`endif
    return 1'b1;
  endfunction

  // Model update on each clock edge from the inputs of the closing cycle.
  always @(posedge clk or negedge reset_n) begin
    bit was_active;
    bit ended;
    int w;
    if (!reset_n) begin
      m_active = 1'b0; m_ticks = 0; m_ptr = 0; m_gid = 0;
      m_dvsr = 11'd53; m_pend_v = 1'b0; m_gnt = 2'b00;
    end else begin
      was_active = m_active;
      ended = 1'b0;
      m_gnt = 2'b00;
      if (was_active) begin
        if (tick) begin
          m_ticks++;
          if (m_ticks == FRAME) begin
            m_active = 1'b0;
            ended = 1'b1;
          end
        end
      end else begin
        w = pick(bus.req_valid, m_ptr);
        if (w >= 0) begin
          m_gnt[w] = 1'b1;
          m_gid = w;
          m_ptr = (w + 1) % NR;
          m_data = bus.req_data[w*DB +: DB];
          m_active = 1'b1;
          m_ticks = 0;
        end
      end
      if (ended) begin
        if (bus.dvsr_we) m_dvsr = bus.dvsr_wdata;
        else if (m_pend_v) m_dvsr = m_pend;
        m_pend_v = 1'b0;
      end else if (bus.dvsr_we) begin
        if (!was_active && m_gnt == 2'b00) m_dvsr = bus.dvsr_wdata;
        else begin
          m_pend = bus.dvsr_wdata;
          m_pend_v = 1'b1;
        end
      end
    end
  end

  // Cycle compare, mid-low-phase after the stimulus has settled.
  always begin
    logic [1:0] er;
    int p;
    @(negedge clk);
    #2;
    if (chk_en) begin
      p = pick(bus.req_valid, m_ptr);
      er = (!reset_n || m_active || p < 0) ? 2'b00 : (2'b01 << p);
      check("tx", 32'(tx), 32'(exp_tx()));
      check("busy", 32'(busy), 32'(m_active));
      check("dvsr", 32'(dvsr), 32'(m_dvsr));
      check("grant_id", 32'(grant_id), 32'(m_gid));
      check("req_ready", 32'(bus.req_ready), 32'(er));
    end
  end

  task automatic wait_idle(input int max_c);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      #2;
      c++;
    end while (busy && c < max_c);
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Sends one byte from requester r with tick every cycle and records the
  // line at the middle of each bit slot plus the busy length.
  task automatic send_directed(input int r, input logic [7:0] d,
                               output logic [10:0] cap, output int bcnt);
    cap = '0;
    bcnt = 0;
    @(negedge clk);
    bus.req_valid = 2'b00;
    bus.req_valid[r] = 1'b1;
    bus.req_data[r*DB +: DB] = d;
    tick = 1'b1;
    #2;
    check("dir_ready", 32'(bus.req_ready[r]), 32'd1);
    for (int c = 1; c <= 220; c++) begin
      @(negedge clk);
      bus.req_valid = 2'b00;
      #2;
      if (busy) bcnt++;
      if (c % 16 == 8 && c / 16 < 11) cap[c / 16] = tx;
    end
  endtask

  initial begin
    logic [10:0] cap;
    logic [9:0]  exp_a5;
    logic [3:0]  exp_g;
    logic [3:0]  got_g;
    int          bcnt, ng, idle_cnt;
    bit          bad;

    bus.req_valid = 2'b00;
    bus.req_data = '0;
    bus.dvsr_we = 1'b0;
    bus.dvsr_wdata = 11'd0;

    // Reset values, with a request pending to show ready stays low.
    @(negedge clk);
    bus.req_valid = 2'b01;
    #2;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dvsr", 32'(dvsr), 32'd53);
    check("rst_gid", 32'(grant_id), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    bus.req_valid = 2'b00;
    reset_n = 1'b1;

    // 8'hA5: start 0, data LSB first 1,0,1,0,0,1,0,1, stop 1.
    exp_a5 = 10'b1101001010;
    send_directed(0, 8'hA5, cap, bcnt);
    for (int k = 0; k < 10; k++) check("a5_bit", 32'(cap[k]), 32'(exp_a5[k]));
    check("a5_busy_len", 32'(bcnt), 32'd160);

`ifdef UART_TX_PARITY_EN
    send_directed(0, 8'h07, cap, bcnt);
    check("par_bit", 32'(cap[9]), 32'd1);
    check("par_stop", 32'(cap[10]), 32'd1);
    check("par_busy_len", 32'(bcnt), 32'd176);
`endif

    // Both requesters valid continuously: pointer sits at 1 after req0 won.
    exp_g = 4'b0101;
    got_g = 4'b0000;
    ng = 0;
    idle_cnt = 0;
    @(negedge clk);
    bus.req_valid = 2'b11;
    bus.req_data = {8'h3C, 8'hC3};
    tick = 1'b1;
    for (int c = 0; c < 800 && ng < 4; c++) begin
      if (c > 0) @(negedge clk);
      #2;
      if (!busy) idle_cnt++;
      if (bus.req_ready != 2'b00) begin
        got_g[ng] = bus.req_ready[1];
        ng++;
      end
    end
    check("alt_count", 32'(ng), 32'd4);
    for (int k = 0; k < 4; k++) check("alt_grant", 32'(got_g[k]), 32'(exp_g[k]));
    check("alt_idle_gap", 32'(idle_cnt), 32'd4);
    @(negedge clk);
    bus.req_valid = 2'b00;
    wait_idle(400);

    // Divisor written mid-frame is deferred to IDLE entry.
    @(negedge clk);
    bus.req_valid = 2'b01;
    bus.req_data[7:0] = 8'h5A;
    bad = 1'b0;
    for (int c = 1; c < 400; c++) begin
      @(negedge clk);
      bus.req_valid = 2'b00;
      bus.dvsr_we = (c == 50);
      bus.dvsr_wdata = 11'd26;
      #2;
      if (!busy) break;
      if (dvsr !== 11'd53) bad = 1'b1;
    end
    check("dvsr_held_mid_frame", 32'(bad), 32'd0);
    check("dvsr_applied_idle", 32'(dvsr), 32'd26);
    check("dvsr_idle_reached", 32'(busy), 32'd0);

    // No ticks in START: line held low, frame does not advance.
    @(negedge clk);
    tick = 1'b0;
    bus.req_valid = 2'b10;
    bus.req_data[15:8] = 8'hFF;
    @(negedge clk);
    bus.req_valid = 2'b00;
    bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #2;
      if (tx !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    check("start_hold", 32'(bad), 32'd0);
    tick = 1'b1;
    wait_idle(400);

    // Asynchronous reset while in DATA abandons the frame.
    @(negedge clk);
    bus.req_valid = 2'b01;
    bus.req_data[7:0] = 8'h00;
    repeat (40) begin
      @(negedge clk);
      bus.req_valid = 2'b00;
    end
    #4;
    reset_n = 1'b0;
    #1;
    check("arst_tx", 32'(tx), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_dvsr", 32'(dvsr), 32'd53);
    @(negedge clk);
    reset_n = 1'b1;
    bus.req_valid = 2'b10;
    bus.req_data[15:8] = 8'h81;
    #2;
    check("arst_regrant", 32'(bus.req_ready), 32'd2);
    bcnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      bus.req_valid = 2'b00;
      #2;
      if (busy) bcnt++;
    end
    check("arst_clean_len", 32'(bcnt), 32'(FRAME));

    // Randomized soak: requesters hold valid/data until accepted.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (!bus.req_valid[i] || m_gnt[i]) begin
          bus.req_valid[i] = ($urandom_range(0, 3) == 0);
          bus.req_data[i*DB +: DB] = 8'($urandom);
        end
      end
      tick = 1'($urandom_range(0, 1));
      bus.dvsr_we = ($urandom_range(0, 49) == 0);
      bus.dvsr_wdata = 11'($urandom);
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
    bus.dvsr_we = 1'b0;
    tick = 1'b1;
    wait_idle(400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
